// File: rtl/arbiter_3_way_rr_if.sv
// Handshake bundle between three requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface arbiter_3_way_rr_if;
    logic [2:0] req;
    logic       done;
    logic [2:0] grant;
    logic [1:0] grant_idx;
    logic       busy;
    logic       any_req;
    logic       timeout;

    modport master (
        output req, done,
        input  grant, grant_idx, busy, any_req, timeout
    );

    modport slave (
        input  req, done,
        output grant, grant_idx, busy, any_req, timeout
    );
endinterface

// File: rtl/arbiter_3_way_rr.sv
// Three-way round-robin arbiter with hold limit and one-cycle turnaround.
// Grants are registered one-hot; priority rotates past the last owner.
module arbiter_3_way_rr #(
    parameter int unsigned HOLD_LIMIT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    arbiter_3_way_rr_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t     r_state;
    logic [2:0] r_grant;
    logic [1:0] r_idx;
    logic       r_busy;
    logic       r_timeout;
    logic [1:0] r_ptr;
    logic [7:0] r_cnt;

    state_t     w_state_nxt;
    logic [2:0] w_grant_nxt;
    logic [1:0] w_idx_nxt;
    logic       w_busy_nxt;
    logic       w_timeout_nxt;
    logic [1:0] w_ptr_nxt;
    logic [7:0] w_cnt_nxt;

    logic       w_any;
    logic [1:0] w_win;
    logic       w_own_req;
    logic       w_at_limit;
    logic [1:0] w_ptr_adv;

    assign w_any       = |bus.req;
    assign bus.any_req = w_any;

    assign w_own_req  = bus.req[r_idx];
    assign w_at_limit = (r_cnt == 8'(HOLD_LIMIT));
    assign w_ptr_adv  = (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;

    // Winner: first set request searching ptr, ptr+1, ptr+2 (mod 3).
    always_comb begin
        w_win = 2'd0;
        unique case (r_ptr)
            2'd0: w_win = bus.req[0] ? 2'd0 :
                          bus.req[1] ? 2'd1 : 2'd2;
            2'd1: w_win = bus.req[1] ? 2'd1 :
                          bus.req[2] ? 2'd2 : 2'd0;
            2'd2: w_win = bus.req[2] ? 2'd2 :
                          bus.req[0] ? 2'd0 : 2'd1;
            default: w_win = 2'd0;
        endcase
    end

    // Next-state and registered-output computation.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_idx_nxt     = r_idx;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_nxt = 3'b001 << w_win;
                    w_idx_nxt   = w_win;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = 8'd1;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (bus.done || !w_own_req || w_at_limit) begin
                    // Timeout only when neither done nor withdrawal caused it.
                    w_timeout_nxt = !bus.done && w_own_req;
                    w_grant_nxt   = 3'b000;
                    w_idx_nxt     = 2'd0;
                    w_busy_nxt    = 1'b0;
                    w_ptr_nxt     = w_ptr_adv;
                    w_cnt_nxt     = 8'd0;
                    w_state_nxt   = TURN;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            TURN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 3'b000;
                w_idx_nxt   = 2'd0;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_grant   <= 3'b000;
            r_idx     <= 2'd0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_ptr     <= 2'd0;
            r_cnt     <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_idx     <= w_idx_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.grant_idx = r_idx;
    assign bus.busy      = r_busy;
    assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_arbiter_3_way_rr.sv
// Bench for arbiter_3_way_rr: directed vectors feed an expectation queue,
// a monitor pops and compares after each clock edge.
module tb_arbiter_3_way_rr;

    logic clk;
    logic rst_n;

    arbiter_3_way_rr_if bus ();

    arbiter_3_way_rr #(.HOLD_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] g;
        logic [1:0] idx;
        logic       b;
        logic       to;
        logic       inv;
        int         id;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;
    event chk_ev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs now (at a negedge), queue result expected after next edge.
    task automatic cyc(input logic [2:0] r, input logic d,
                       input logic [2:0] eg, input logic [1:0] ei,
                       input logic eb, input logic et);
        exp_t e;
        bus.req  = r;
        bus.done = d;
        step++;
        e.g = eg; e.idx = ei; e.b = eb; e.to = et;
        e.inv = 1'b0; e.id = step;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_now(input exp_t e);
        total++;
        if (e.inv) begin
            if (!$onehot0(bus.grant)) begin
                bad++;
                $display("FAIL onehot step%0d: grant=%b required zero or one-hot",
                         e.id, bus.grant);
            end
            total++;
            if (bus.any_req !== (|bus.req)) begin
                bad++;
                $display("FAIL any_req step%0d: got %b required %b req=%b",
                         e.id, bus.any_req, |bus.req, bus.req);
            end
        end else if ({bus.grant, bus.grant_idx, bus.busy, bus.timeout} !==
                     {e.g, e.idx, e.b, e.to}) begin
            bad++;
            $display("FAIL step%0d: got grant=%b idx=%0d busy=%b to=%b required grant=%b idx=%0d busy=%b to=%b",
                     e.id, bus.grant, bus.grant_idx, bus.busy, bus.timeout,
                     e.g, e.idx, e.b, e.to);
        end
    endtask

    // Monitor: after each edge (or an async-reset probe) pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_now(e);
            end
        end
    end

    initial begin
        exp_t e;
        rst_n    = 1'b0;
        bus.req  = 3'b000;
        bus.done = 1'b0;
        repeat (2) @(negedge clk);

        // Reset held with all requesting
        cyc(3'b111, 0, 3'b000, 0, 0, 0);
        rst_n = 1'b1;
        cyc(3'b111, 0, 3'b001, 0, 1, 0);
        // Rotation 0 -> 1 -> 2 -> 0
        cyc(3'b111, 1, 3'b000, 0, 0, 0);
        cyc(3'b111, 0, 3'b000, 0, 0, 0);
        cyc(3'b111, 0, 3'b010, 1, 1, 0);
        cyc(3'b111, 1, 3'b000, 0, 0, 0);
        cyc(3'b111, 0, 3'b000, 0, 0, 0);
        cyc(3'b111, 0, 3'b100, 2, 1, 0);
        cyc(3'b111, 1, 3'b000, 0, 0, 0);
        cyc(3'b111, 0, 3'b000, 0, 0, 0);
        cyc(3'b111, 0, 3'b001, 0, 1, 0);
        // Skip idle requesters, ptr=1
        cyc(3'b001, 1, 3'b000, 0, 0, 0);
        cyc(3'b001, 0, 3'b000, 0, 0, 0);
        cyc(3'b001, 0, 3'b001, 0, 1, 0);
        cyc(3'b101, 1, 3'b000, 0, 0, 0);
        cyc(3'b101, 0, 3'b000, 0, 0, 0);
        cyc(3'b101, 0, 3'b100, 2, 1, 0);
        // Owner withdraws alone, ptr -> 0
        cyc(3'b001, 0, 3'b000, 0, 0, 0);
        cyc(3'b000, 0, 3'b000, 0, 0, 0);
        cyc(3'b000, 0, 3'b000, 0, 0, 0);
        // Timeout with limit 4
        cyc(3'b010, 0, 3'b010, 1, 1, 0);
        cyc(3'b010, 0, 3'b010, 1, 1, 0);
        cyc(3'b010, 0, 3'b010, 1, 1, 0);
        cyc(3'b010, 0, 3'b010, 1, 1, 0);
        cyc(3'b010, 0, 3'b000, 0, 0, 1);
        cyc(3'b010, 0, 3'b000, 0, 0, 0);
        cyc(3'b010, 0, 3'b010, 1, 1, 0);
        // Withdraw and done together
        cyc(3'b000, 1, 3'b000, 0, 0, 0);
        cyc(3'b000, 0, 3'b000, 0, 0, 0);
        // Done on the limit edge
        cyc(3'b100, 0, 3'b100, 2, 1, 0);
        cyc(3'b100, 0, 3'b100, 2, 1, 0);
        cyc(3'b100, 0, 3'b100, 2, 1, 0);
        cyc(3'b100, 0, 3'b100, 2, 1, 0);
        cyc(3'b100, 1, 3'b000, 0, 0, 0);
        // done outside GRANT ignored; non-owner requests ignored
        cyc(3'b100, 1, 3'b000, 0, 0, 0);
        cyc(3'b100, 1, 3'b100, 2, 1, 0);
        cyc(3'b111, 0, 3'b100, 2, 1, 0);
        cyc(3'b111, 0, 3'b100, 2, 1, 0);
        // Async reset mid-grant, counter=3
        #2;
        rst_n = 1'b0;
        step++;
        e.g = 3'b000; e.idx = 0; e.b = 0; e.to = 0;
        e.inv = 1'b0; e.id = step;
        q.push_back(e);
        -> chk_ev;
        @(negedge clk);
        cyc(3'b111, 0, 3'b000, 0, 0, 0);
        rst_n = 1'b1;
        cyc(3'b111, 0, 3'b001, 0, 1, 0);

        // Random traffic: invariant checks only
        for (int i = 0; i < 128; i++) begin
            bus.req  = 3'($urandom_range(0, 7));
            bus.done = ($urandom_range(0, 3) == 0);
            step++;
            e.g = 0; e.idx = 0; e.b = 0; e.to = 0;
            e.inv = 1'b1; e.id = step;
            q.push_back(e);
            @(negedge clk);
        end

        repeat (20) begin
            if (q.size() > 0) @(negedge clk);
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arbiter_3_way_rr.md
Name: arbiter_3_way_rr

Overview:
Round-robin arbiter that shares one downstream resource (e.g. the memory/ALU bus) between three requesters. Issues one-hot grants and holds each grant until the owner completes, withdraws, or exceeds a hold limit. After every grant a one-cycle turnaround follows, then priority rotates. Sits between the requester blocks and the shared resource; any_req is the 3-way OR of the request lines.

Parameters:
HOLD_LIMIT, 16, maximum cycles a single grant may be held before forced release (legal range 1..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  3  request lines; bit i = requester i
done  input  1  resource signals the current owner's transaction is complete (sampled only in GRANT)
grant  output  3  one-hot grant, registered; 3'b000 when no owner
grant_idx  output  2  index of current owner (0..2); 2'd0 when grant==0
busy  output  1  high while in GRANT state
any_req  output  1  combinational OR of req[2:0]
timeout  output  1  one-cycle registered pulse when a grant is force-released by HOLD_LIMIT

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, grant=0, grant_idx=0, busy=0, timeout=0, priority pointer ptr=0, hold counter=0. Release is honoured at the next clk edge.
- any_req = req[0]|req[1]|req[2], purely combinational, no reset dependence.
- States: IDLE, GRANT, TURN.
- IDLE: if any_req at an edge, pick the winner as the first set req bit searching ptr, ptr+1, ptr+2 (mod 3). At that edge: grant=onehot(winner), grant_idx=winner, busy=1, counter=1, state→GRANT. Latency: req sampled high at edge N → grant visible after edge N. If no request, stay in IDLE with outputs 0.
- GRANT, evaluated at each edge, in priority order:
  1. done=1 → release (normal).
  2. req[grant_idx]=0 → release (withdrawn).
  3. counter==HOLD_LIMIT → release and set timeout=1 for exactly one cycle.
  4. Otherwise counter+1, hold grant.
- Release: grant=0, grant_idx=0, busy=0, ptr=(winner+1) mod 3, counter=0, state→TURN.
- done and withdrawal at the same edge: treat as normal release (no timeout). done at the same edge as the limit: normal release, timeout stays 0.
- TURN: exactly one cycle with grant=0. timeout clears. Unconditionally →IDLE. A new grant therefore appears no earlier than 2 edges after release.
- Counter is 8 bits, saturates conceptually at HOLD_LIMIT and never wraps.
- ptr takes only the values 0..2; the wrap is 2→0.
- grant is always zero or one-hot; never more than one bit set.
- req changes from non-owners during GRANT are ignored.
- done outside GRANT is ignored.
- Reset asserted mid-GRANT clears everything immediately, with no timeout pulse.

Test Plan:
- Reset: hold rst_n=0 with req=3'b111 → grant=000, busy=0, timeout=0. Release rst_n, then at the next edge → grant=001, grant_idx=0.
- Rotation: req=3'b111 held; pulse done for 1 cycle in each grant → grant sequence 001,000,010,000,100,000,001; ptr wraps 2→0.
- Skip idle requesters: after ptr=1 (owner 0 released), req=3'b001 → grant=001 (search 1,2,0). Then req=3'b101 with ptr=1 → grant=100.
- Timeout: HOLD_LIMIT=4, req=3'b010 held, done=0 → grant=010 for exactly 4 cycles, then timeout=1 for one cycle with grant=000. Next grant is again 010 two edges after release.
- Withdrawal vs done: owner drops req and done=1 on the same edge → release, timeout=0. Owner drops req alone → release after that edge, ptr advances.
- Async reset mid-grant: grant=100 with counter=3, assert rst_n=0 between edges → grant=000, busy=0 immediately without waiting for clk. Randomised 128-cycle req/done traffic → grant is always zero or one-hot and any_req==|req.
